// File: rtl/uart_pkg.sv
// ============================================================================
//  Module      : uart_pkg
//  Description : Baud-code and parity encodings shared by the UART receive
//                path, transmit path and the transmit arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [1:0] {
        BAUD_2400  = 2'b00,
        BAUD_4800  = 2'b01,
        BAUD_9600  = 2'b10,
        BAUD_19200 = 2'b11
    } baud_t;

    localparam logic PARITY_ODD  = 1'b0;
    localparam logic PARITY_EVEN = 1'b1;

    // Bit-period divisor in clock cycles, rounded to nearest.
    function automatic int unsigned baud_div(input int unsigned clk_freq, input baud_t code);
        int unsigned baud;
        baud = 2400;
        case (code)
            BAUD_2400:  baud = 2400;
            BAUD_4800:  baud = 4800;
            BAUD_9600:  baud = 9600;
            BAUD_19200: baud = 19200;
            default:    baud = 2400;
        endcase
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rr_arbiter.sv
// ============================================================================
//  Module      : uart_rr_arbiter
//  Description : Combinational round-robin select; search starts at last+1.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] last_i,
    output logic [NUM_REQ-1:0]         onehot_o,
    output logic [$clog2(NUM_REQ)-1:0] idx_o,
    output logic                       valid_o
);

    localparam int IDW = $clog2(NUM_REQ);

    int             idx;
    logic [IDW-1:0] sel;

    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        idx      = 0;
        sel      = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = (int'(last_i) + off) % NUM_REQ;
            sel = idx[IDW-1:0];
            if (!valid_o && req_i[sel]) begin
                valid_o       = 1'b1;
                onehot_o[sel] = 1'b1;
                idx_o         = sel;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Shares one UART transmitter among NUM_REQ requesters with
//                per-requester baud/parity and an idle guard gap per frame.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int CLK_FREQ      = 50_000_000,
    parameter int GUARD_BITS    = 1,
    parameter int START_TIMEOUT = 8
) (
    input  logic                       clock,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [8*NUM_REQ-1:0]       reqData,
    input  logic [2*NUM_REQ-1:0]       reqBaud,
    input  logic [NUM_REQ-1:0]         reqPType,
    output logic [NUM_REQ-1:0]         grant,
    output logic [7:0]                 txData,
    output logic [1:0]                 baudRate,
    output logic                       pType,
    output logic                       txStart,
    input  logic                       txBusy,
    output logic                       active,
    output logic [$clog2(NUM_REQ)-1:0] activeId
);

    localparam int          IDW     = $clog2(NUM_REQ);
    localparam int unsigned DIV_MAX = baud_div(CLK_FREQ, BAUD_2400);
    localparam int          CNT_W   = $clog2(4 * DIV_MAX + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(START_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_START     = 3'd2,
        S_WAIT_BUSY = 3'd3,
        S_SEND      = 3'd4,
        S_GUARD     = 3'd5
    } state_t;

    state_t             state_q;
    logic [NUM_REQ-1:0] win_q;
    logic [IDW-1:0]     win_idx_q;
    logic [IDW-1:0]     last_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [7:0]         txData_q;
    baud_t              baud_q;
    logic               pType_q;
    logic               txStart_q;
    logic               active_q;
    logic [IDW-1:0]     activeId_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [NUM_REQ-1:0] arb_onehot;
    logic [IDW-1:0]     arb_idx;
    logic               arb_valid;
    logic [CNT_W-1:0]   guard_last;

    uart_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req_i    (req),
        .last_i   (last_q),
        .onehot_o (arb_onehot),
        .idx_o    (arb_idx),
        .valid_o  (arb_valid)
    );

    assign guard_last = CNT_W'(GUARD_BITS * baud_div(CLK_FREQ, baud_q) - 1);

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            win_q      <= '0;
            win_idx_q  <= '0;
            last_q     <= IDW'(NUM_REQ - 1);
            grant_q    <= '0;
            txData_q   <= 8'h00;
            baud_q     <= BAUD_2400;
            pType_q    <= PARITY_ODD;
            txStart_q  <= 1'b0;
            active_q   <= 1'b0;
            activeId_q <= '0;
            cnt_q      <= '0;
        end else begin
            grant_q   <= '0;
            txStart_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (arb_valid) begin
                        win_q     <= arb_onehot;
                        win_idx_q <= arb_idx;
                        state_q   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // A requester that dropped req since IDLE is withdrawn.
                    if (|(req & win_q)) begin
                        grant_q    <= win_q;
                        txData_q   <= reqData[{win_idx_q, 3'b000} +: 8];
                        baud_q     <= baud_t'(reqBaud[{win_idx_q, 1'b0} +: 2]);
                        pType_q    <= reqPType[win_idx_q];
                        activeId_q <= win_idx_q;
                        last_q     <= win_idx_q;
                        active_q   <= 1'b1;
                        state_q    <= S_START;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_START: begin
                    txStart_q <= 1'b1;
                    cnt_q     <= '0;
                    state_q   <= txBusy ? S_SEND : S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (txBusy) begin
                        state_q <= S_SEND;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= S_GUARD;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_SEND: begin
                    if (!txBusy) begin
                        cnt_q   <= '0;
                        state_q <= S_GUARD;
                    end
                end
                S_GUARD: begin
                    if (cnt_q == guard_last) begin
                        cnt_q    <= '0;
                        active_q <= 1'b0;
                        state_q  <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign grant    = grant_q;
    assign txData   = txData_q;
    assign baudRate = baud_q;
    assign pType    = pType_q;
    assign txStart  = txStart_q;
    assign active   = active_q;
    assign activeId = activeId_q;

endmodule

`default_nettype wire

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one UART transmitter among `NUM_REQ` requesters, each with its own baud rate and parity setting. Per frame it latches the winning requester's byte and line configuration, programs the transmitter's `txData`/`baudRate`/`pType`, pulses `txStart`, tracks `txBusy`, and inserts an idle guard gap before the next grant. It sits between client logic and the transmitter, with the same baud-code and parity conventions as the receive path.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `CLK_FREQ`, 50_000_000: clock frequency in Hz, used for bit-period divisors.
- `GUARD_BITS`, 1: idle bit periods inserted after each frame (1..4).
- `START_TIMEOUT`, 8: cycles allowed for `txBusy` to rise after `txStart`.

Ports:
- `clock`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  NUM_REQ  per-requester request level.
- `reqData`  in  8*NUM_REQ  byte i in bits [8i+7:8i].
- `reqBaud`  in  2*NUM_REQ  baud code i in bits [2i+1:2i]: 00 = 2400, 01 = 4800, 10 = 9600, 11 = 19200.
- `reqPType`  in  NUM_REQ  parity per requester: 0 = odd, 1 = even.
- `grant`  out  NUM_REQ  one-hot, one-cycle acknowledge; the byte is captured in that cycle.
- `txData`  out  8  byte to the transmitter.
- `baudRate`  out  2  baud code to the transmitter.
- `pType`  out  1  parity type to the transmitter.
- `txStart`  out  1  one-cycle frame start pulse.
- `txBusy`  in  1  transmitter frame in progress.
- `active`  out  1  high from grant until the guard gap ends.
- `activeId`  out  $clog2(NUM_REQ)  index of the current or last granted requester.

## Operation
- Requester handshake:
  - The requester raises `req` and holds its data and config stable until `grant[i]` is seen.
  - `req` may drop after the grant.
  - A requester that drops `req` before its grant is withdrawn and never served.
- Arbitration:
  - Round-robin. The search starts at index `last+1` and wraps modulo `NUM_REQ`.
  - `last` resets to `NUM_REQ-1`, so index 0 has first priority after reset.
  - Only `req` levels sampled in IDLE are considered.
- FSM states:
  - IDLE: if any `req` is high, go to LOAD. Otherwise stay.
  - LOAD (1 cycle): `grant[w]` = 1. Latch `txData`, `baudRate`, `pType`, `activeId` = w, `last` = w. `active` = 1. Go to START.
  - START (1 cycle): `txStart` = 1. Go to WAIT_BUSY.
  - WAIT_BUSY: when `txBusy` = 1, go to SEND. After `START_TIMEOUT` cycles with no `txBusy`, go to GUARD; the frame is dropped and not retried.
  - SEND: when `txBusy` = 0, go to GUARD.
  - GUARD: count `GUARD_BITS*DIV[baudRate]` cycles, then clear `active` and go to IDLE.
- Configuration stability:
  - `txData`, `baudRate` and `pType` change only in LOAD.
  - Between frames they hold their last values and never glitch.
- Reset values: `grant` = 0, `txData` = 0x00, `baudRate` = 00, `pType` = 0, `txStart` = 0, `active` = 0, `activeId` = 0, state IDLE, `last` = NUM_REQ-1, counters 0.
- Reset mid-frame: all outputs and state return to reset values asynchronously. No grant or `txStart` may be issued while `rst` = 1.

## Timing
- `req` high before edge k in IDLE gives:
  - `grant`, `txData`, `baudRate`, `pType` valid after edge k+1.
  - `txStart` high for one cycle after edge k+2.
  - Configuration is stable for at least one cycle before `txStart`.
- Divisors are `round(CLK_FREQ/baud)`. At 50 MHz: 20833, 10417, 5208, 2604.
- The guard counter is wide enough for `4*20833`: 17 bits at 50 MHz.
- Back-to-back spacing from the fall of `txBusy` to the next `grant` is the guard length plus 1 cycle (GUARD to IDLE to LOAD).
- Simultaneous requests produce exactly one grant per LOAD. The others stay pending.
- If `txBusy` is already high in START, SEND is entered on the next cycle.

## Structure
- Shared package `uart_pkg`:
  - baud code typedef `baud_t` (2 bits) and its 4 encodings;
  - parity constants `PARITY_ODD` = 0, `PARITY_EVEN` = 1;
  - function `baud_div(clk_freq, code)` returning the divisor.
- The receiver and transmitter import the same package.
- Sub-module `uart_rr_arbiter`: combinational round-robin winner select from `req` and `last`, producing a one-hot winner and its index. The FSM, latches and counters live in the top.

## Test plan
- Reset: hold `rst` = 1 with `req` = 4'hF → all outputs 0 and no `txStart`. After release, `grant` = 4'b0001 within 2 cycles.
- Single frame: `req[1]`, `reqData` byte 1 = 0xA5, baud 11, `pType` 1 → `grant` = 4'b0010 for one cycle, `txData` = 0xA5, `baudRate` = 11, `pType` = 1. `txStart` follows one cycle later. The next grant comes no earlier than 2604+1 cycles after `txBusy` falls.
- Fairness: `req` = 4'hF held continuously, TxUnit model busy for 11 bit periods → grants in order 0, 1, 2, 3, 0. Each `baudRate` matches the granted requester's code.
- Starvation: `req[0]` held permanently while `req[2]` pulses → alternating grants 0, 2, 0, 2.
- Withdrawal and timeout:
  - `req[3]` dropped during another requester's frame → `grant[3]` never asserted.
  - `txBusy` tied to 0 → after `START_TIMEOUT` cycles the arbiter enters GUARD, then serves the next requester.
- Reset mid-frame: assert `rst` in SEND at baud 00 → `active`, `txStart`, `grant` go to 0 immediately and `baudRate` = 00. After release, requester 0 is served first.
